// File: rtl/forward_router_buffered_pkg.sv
// Shared router constants: hop-field bit positions, dx step per direction, output select.
package forward_router_buffered_pkg;

    localparam int unsigned FR_DX_MSB = 29;
    localparam int unsigned FR_DX_LSB = 21;
    localparam int unsigned FR_DY_MSB = 20;
    localparam int unsigned FR_DY_LSB = 12;

    localparam int FR_ADD_EAST = -1;
    localparam int FR_ADD_WEST = 1;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2
    } out_sel_e;

endpackage

// File: rtl/forward_router_buffered_if.sv
// Input stream, three output streams and status for one forwarding router.
interface forward_router_buffered_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 23,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_wen;
    logic                  din_full;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  wen_a;
    logic                  full_a;
    logic [OUT_WIDTH-1:0]  dout_b;
    logic                  wen_b;
    logic                  full_b;
    logic [OUT_WIDTH-1:0]  dout_c;
    logic                  wen_c;
    logic                  full_c;
    logic [CNT_WIDTH-1:0]  cnt_a;
    logic [CNT_WIDTH-1:0]  cnt_b;
    logic [CNT_WIDTH-1:0]  cnt_c;
    logic                  overflow;

    modport master (
        output din, din_wen, full_a, full_b, full_c,
        input  din_full, dout_a, wen_a, dout_b, wen_b, dout_c, wen_c,
        input  cnt_a, cnt_b, cnt_c, overflow
    );

    modport slave (
        input  din, din_wen, full_a, full_b, full_c,
        output din_full, dout_a, wen_a, dout_b, wen_b, dout_c, wen_c,
        output cnt_a, cnt_b, cnt_c, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A write while full is dropped even when a pop frees a slot in the same cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign rdata_c   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/forward_router_buffered.sv
// Buffered forwarding router: decodes the FIFO head's dx/dy hops and steers it to continue (a), north (b) or south (c).
module forward_router_buffered
    import forward_router_buffered_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DX_MSB     = FR_DX_MSB,
    parameter int unsigned DX_LSB     = FR_DX_LSB,
    parameter int unsigned DY_MSB     = FR_DY_MSB,
    parameter int unsigned DY_LSB     = FR_DY_LSB,
    parameter int          ADD        = FR_ADD_EAST,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    forward_router_buffered_if.slave  bus
);
    localparam int unsigned DXW   = DX_MSB - DX_LSB + 1;
    localparam int unsigned OUT_W = DATA_WIDTH - (DX_MSB - DY_MSB);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] head_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    out_sel_e              sel_c;
    logic                  sel_full_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] fwd_a_c;
    logic [OUT_W-1:0]      strip_c;

    logic [DATA_WIDTH-1:0] dout_a_q;
    logic [OUT_W-1:0]      dout_b_q;
    logic [OUT_W-1:0]      dout_c_q;
    logic                  wen_a_q, wen_b_q, wen_c_q;
    logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_b_q, cnt_c_q;
    logic                  overflow_q;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.din_wen),
        .pop     (pop_c),
        .wdata   (bus.din),
        .rdata_c (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head decode; dy sign is its MSB.
    always_comb begin
        sel_c      = SEL_A;
        sel_full_c = bus.full_a;
        fwd_a_c    = head_c;
        if (head_c[DX_MSB:DX_LSB] != '0) begin
            sel_c = SEL_A;
        end else if (!head_c[DY_MSB]) begin
            sel_c = SEL_B;
        end else begin
            sel_c = SEL_C;
        end
        case (sel_c)
            SEL_B:   sel_full_c = bus.full_b;
            SEL_C:   sel_full_c = bus.full_c;
            default: sel_full_c = bus.full_a;
        endcase
        fwd_a_c[DX_MSB:DX_LSB] = head_c[DX_MSB:DX_LSB] + DXW'(ADD);
    end

    assign pop_c = !fifo_empty && !sel_full_c;

    // North/south packets leave with the dx field removed.
    generate
        if (DX_MSB == DATA_WIDTH - 1) begin : g_strip_top
            assign strip_c = head_c[DX_LSB-1:0];
        end else begin : g_strip_mid
            assign strip_c = {head_c[DATA_WIDTH-1:DX_MSB+1], head_c[DX_LSB-1:0]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            dout_c_q   <= '0;
            wen_a_q    <= 1'b0;
            wen_b_q    <= 1'b0;
            wen_c_q    <= 1'b0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            cnt_c_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wen_a_q <= pop_c && (sel_c == SEL_A);
            wen_b_q <= pop_c && (sel_c == SEL_B);
            wen_c_q <= pop_c && (sel_c == SEL_C);
            if (pop_c && (sel_c == SEL_A)) begin
                dout_a_q <= fwd_a_c;
                if (cnt_a_q != CNT_MAX) cnt_a_q <= cnt_a_q + CNT_WIDTH'(1);
            end
            if (pop_c && (sel_c == SEL_B)) begin
                dout_b_q <= strip_c;
                if (cnt_b_q != CNT_MAX) cnt_b_q <= cnt_b_q + CNT_WIDTH'(1);
            end
            if (pop_c && (sel_c == SEL_C)) begin
                dout_c_q <= strip_c;
                if (cnt_c_q != CNT_MAX) cnt_c_q <= cnt_c_q + CNT_WIDTH'(1);
            end
            if (bus.din_wen && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign bus.din_full = fifo_full;
    assign bus.dout_a   = dout_a_q;
    assign bus.dout_b   = dout_b_q;
    assign bus.dout_c   = dout_c_q;
    assign bus.wen_a    = wen_a_q;
    assign bus.wen_b    = wen_b_q;
    assign bus.wen_c    = wen_c_q;
    assign bus.cnt_a    = cnt_a_q;
    assign bus.cnt_b    = cnt_b_q;
    assign bus.cnt_c    = cnt_c_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_forward_router_buffered.sv
// Bench for forward_router_buffered: queue-based reference model, per-cycle compare, directed literal checks, random traffic.
module tb_forward_router_buffered;
    import forward_router_buffered_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = DW - (FR_DX_MSB - FR_DY_MSB);
    localparam int unsigned FD  = 4;
    localparam int unsigned DXW = FR_DX_MSB - FR_DX_LSB + 1;
    localparam int unsigned DYW = FR_DY_MSB - FR_DY_LSB + 1;

    logic clk;
    logic rst;

    forward_router_buffered_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(16)) bus ();
    forward_router_buffered_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(2))  bus2 ();

    forward_router_buffered #(
        .DATA_WIDTH(DW), .DX_MSB(FR_DX_MSB), .DX_LSB(FR_DX_LSB), .DY_MSB(FR_DY_MSB),
        .DY_LSB(FR_DY_LSB), .ADD(FR_ADD_EAST), .FIFO_DEPTH(FD), .CNT_WIDTH(16)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    forward_router_buffered #(
        .DATA_WIDTH(DW), .DX_MSB(FR_DX_MSB), .DX_LSB(FR_DX_LSB), .DY_MSB(FR_DY_MSB),
        .DY_LSB(FR_DY_LSB), .ADD(FR_ADD_EAST), .FIFO_DEPTH(FD), .CNT_WIDTH(2)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.din     = bus.din;
    assign bus2.din_wen = bus.din_wen;
    assign bus2.full_a  = bus.full_a;
    assign bus2.full_b  = bus.full_b;
    assign bus2.full_c  = bus.full_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] e_dout_a;
    logic [OW-1:0] e_dout_b, e_dout_c;
    bit            e_wen_a, e_wen_b, e_wen_c, e_ovf;
    int            n_a, n_b, n_c;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] sat(int n, int mx);
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    function automatic void model_reset();
        q.delete();
        e_dout_a = '0; e_dout_b = '0; e_dout_c = '0;
        e_wen_a = 0; e_wen_b = 0; e_wen_c = 0; e_ovf = 0;
        n_a = 0; n_b = 0; n_c = 0;
    endfunction

    // One clock edge of the routing rules, computed on the pre-edge state.
    function automatic void model_update();
        logic [DW-1:0] h;
        int dx, dy, dxmask, dymask;
        bit was_full;
        dxmask = (1 << DXW) - 1;
        dymask = (1 << DYW) - 1;
        if (rst) begin
            model_reset();
            return;
        end
        e_wen_a = 0; e_wen_b = 0; e_wen_c = 0;
        was_full = (q.size() == FD);
        if (q.size() > 0) begin
            h  = q[0];
            dx = int'(h >> FR_DX_LSB) & dxmask;
            dy = int'(h >> FR_DY_LSB) & dymask;
            if (dx != 0) begin
                if (!bus.full_a) begin
                    void'(q.pop_front());
                    e_wen_a  = 1; n_a++;
                    e_dout_a = (h & ~(DW'(dxmask) << FR_DX_LSB)) |
                               (DW'((dx + FR_ADD_EAST) & dxmask) << FR_DX_LSB);
                end
            end else if (dy < (1 << (DYW - 1))) begin
                if (!bus.full_b) begin
                    void'(q.pop_front());
                    e_wen_b  = 1; n_b++;
                    e_dout_b = OW'(((h >> (FR_DX_MSB + 1)) << FR_DX_LSB) | (h & ((DW'(1) << FR_DX_LSB) - 1)));
                end
            end else begin
                if (!bus.full_c) begin
                    void'(q.pop_front());
                    e_wen_c  = 1; n_c++;
                    e_dout_c = OW'(((h >> (FR_DX_MSB + 1)) << FR_DX_LSB) | (h & ((DW'(1) << FR_DX_LSB) - 1)));
                end
            end
        end
        if (bus.din_wen) begin
            if (was_full) e_ovf = 1;
            else          q.push_back(bus.din);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("din_full", bus.din_full, q.size() == FD);
            chk("wen_a", bus.wen_a, e_wen_a);
            chk("wen_b", bus.wen_b, e_wen_b);
            chk("wen_c", bus.wen_c, e_wen_c);
            chk("dout_a", bus.dout_a, e_dout_a);
            chk("dout_b", bus.dout_b, e_dout_b);
            chk("dout_c", bus.dout_c, e_dout_c);
            chk("cnt_a", bus.cnt_a, sat(n_a, 65535));
            chk("cnt_b", bus.cnt_b, sat(n_b, 65535));
            chk("cnt_c", bus.cnt_c, sat(n_c, 65535));
            chk("overflow", bus.overflow, e_ovf);
            chk("cnt2_a", bus2.cnt_a, sat(n_a, 3));
            chk("cnt2_b", bus2.cnt_b, sat(n_b, 3));
            chk("cnt2_c", bus2.cnt_c, sat(n_c, 3));
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] d, input bit fa, input bit fb, input bit fc);
        bus.din_wen = w;
        bus.din     = d;
        bus.full_a  = fa;
        bus.full_b  = fb;
        bus.full_c  = fc;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1;
        bus.din = '0; bus.din_wen = 0; bus.full_a = 0; bus.full_b = 0; bus.full_c = 0;
        model_reset();
        #1;
        chk("rst_dout_a", bus.dout_a, 32'h0);
        chk("rst_din_full", bus.din_full, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk_en = 1'b1;
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        rst = 1'b0;
        step(0, '0, 0, 0, 0);

        // dx=3,dy=0 continues with dx=2, two cycles after the push
        step(1, 32'h0060_0ABC, 0, 0, 0);
        chk("lat_wen_a_early", bus.wen_a, 1'b0);
        step(0, '0, 0, 0, 0);
        chk("lat_wen_a", bus.wen_a, 1'b1);
        chk("lat_dout_a", bus.dout_a, 32'h0040_0ABC);
        chk("lat_cnt_a", bus.cnt_a, 16'd1);
        step(0, '0, 0, 0, 0);

        // dx=0, dy=-1 -> south; dx=0, dy=0 -> north
        step(1, 32'hC01F_F005, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("south_wen_c", bus.wen_c, 1'b1);
        chk("south_dout_c", bus.dout_c, 23'h7F_F005);
        step(1, 32'h0000_0123, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("north_wen_b", bus.wen_b, 1'b1);
        chk("north_dout_b", bus.dout_b, 23'h00_0123);

        // Fill while blocked, drop the fifth, then drain back-to-back
        for (int i = 1; i <= 4; i++) step(1, 32'h00A0_0000 | DW'(i), 1, 0, 0);
        chk("fill_full", bus.din_full, 1'b1);
        chk("fill_no_ovf", bus.overflow, 1'b0);
        step(1, 32'h00A0_0005, 1, 0, 0);
        chk("drop_ovf", bus.overflow, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(0, '0, 0, 0, 0);
            chk("drain_wen_a", bus.wen_a, 1'b1);
            chk("drain_dout_a", bus.dout_a, 32'h0080_0000 | DW'(i));
        end
        step(0, '0, 0, 0, 0);
        chk("drain_done", bus.wen_a, 1'b0);

        // Blocked head to a must keep a later north packet waiting
        step(1, 32'h0020_0011, 1, 0, 0);
        step(1, 32'h0000_1022, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0, 0);
            chk("order_wen_b_held", bus.wen_b, 1'b0);
        end
        step(0, '0, 0, 0, 0);
        chk("order_first_a", bus.wen_a, 1'b1);
        chk("order_first_dout", bus.dout_a, 32'h0000_0011);
        step(0, '0, 0, 0, 0);
        chk("order_then_b", bus.wen_b, 1'b1);
        chk("order_then_dout", bus.dout_b, 23'h00_1022);

        // Reset with three packets buffered
        for (int i = 1; i <= 3; i++) step(1, 32'h0020_0000 | DW'(i), 1, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("mrst_dout_a", bus.dout_a, 32'h0);
        chk("mrst_dout_b", bus.dout_b, 23'h0);
        chk("mrst_dout_c", bus.dout_c, 23'h0);
        chk("mrst_cnt_a", bus.cnt_a, 16'h0);
        chk("mrst_din_full", bus.din_full, 1'b0);
        chk("mrst_overflow", bus.overflow, 1'b0);
        @(negedge clk);
        step(0, '0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(0, '0, 0, 0, 0);
            chk("post_rst_no_wen", {bus.wen_a, bus.wen_b, bus.wen_c}, 3'b000);
        end

        // Narrow counter saturates
        for (int i = 1; i <= 5; i++) step(1, 32'h0000_0040 + DW'(i), 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        chk("sat_cnt2_b", bus2.cnt_b, 2'd3);
        chk("sat_cnt_b", bus.cnt_b, 16'd5);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            d = DW'($urandom);
            if ($urandom_range(0, 1) == 0) d = d & ~(DW'((1 << DXW) - 1) << FR_DX_LSB);
            step($urandom_range(0, 9) < 6, d,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 8; i++) step(0, '0, 0, 0, 0);
        chk("drain_empty", bus.din_full, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/forward_router_buffered.md
FORWARD_ROUTER_BUFFERED -- requirements
Module: forward_router_buffered

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, packet width in bits.
REQ-002 SHALL have parameters DX_MSB/DX_LSB, defaults 29/21, bit range of the signed dx hop field.
REQ-003 SHALL have parameters DY_MSB/DY_LSB, defaults 20/12, bit range of the signed dy hop field.
REQ-004 SHALL have parameter ADD, default -1, dx increment (-1 forward east, +1 forward west).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries; power of two, >= 2.
REQ-006 SHALL have parameter CNT_WIDTH, default 16, width of the per-output packet counters.
REQ-007 SHALL have one clock and an asynchronous, active-high reset: clk input 1 system clock; rst input 1 async active-high reset.
REQ-008 SHALL have ports: din input DATA_WIDTH packet in; din_wen input 1 write strobe; din_full output 1 buffer full.
REQ-009 SHALL have ports: dout_a output DATA_WIDTH; wen_a output 1; full_a input 1 (continue-direction output).
REQ-010 SHALL have ports: dout_b output DATA_WIDTH-(DX_MSB-DY_MSB); wen_b output 1; full_b input 1 (forward north).
REQ-011 SHALL have ports: dout_c output DATA_WIDTH-(DX_MSB-DY_MSB); wen_c output 1; full_c input 1 (forward south).
REQ-012 SHALL have ports: cnt_a, cnt_b, cnt_c output CNT_WIDTH each, packets forwarded per output; overflow output 1 sticky drop flag.

Function
REQ-013 SHALL buffer packets in a FIFO_DEPTH-entry FIFO; push when din_wen=1 and din_full=0.
REQ-014 SHALL drive din_full=1 exactly when the FIFO holds FIFO_DEPTH entries; a push while full SHALL be discarded even if a pop occurs in the same cycle, and overflow SHALL be set to 1 and held until reset.
REQ-015 SHALL decode the FIFO head: dx!=0 -> output a; dx==0 and dy>=0 -> output b; dx==0 and dy<0 -> output c.
REQ-016 SHALL pop the head in a cycle when the FIFO is non-empty and the full input of the selected output is 0; otherwise the head SHALL stall with no reordering.
REQ-017 On pop to a, SHALL register dout_a = din with dx replaced by (dx+ADD) modulo 2^(DX_MSB-DX_LSB+1), all other bits unchanged.
REQ-018 On pop to b or c, SHALL register that dout with the dx field removed: {din[DATA_WIDTH-1:DX_MSB+1], din[DX_LSB-1:0]}, upper part omitted when DX_MSB=DATA_WIDTH-1.
REQ-019 SHALL assert the selected wen_x for exactly one cycle, the cycle after the pop; at most one wen_x SHALL be high per cycle; dout_x SHALL hold its last value otherwise.
REQ-020 Latency: a packet pushed into an empty FIFO at cycle N with its target not full SHALL appear with wen_x=1 at cycle N+2; sustained throughput SHALL be one packet per cycle.
REQ-021 full_x SHALL be treated as almost-full: downstream SHALL accept one wen_x after raising full_x.
REQ-022 SHALL increment cnt_x on each wen_x; counters SHALL saturate at 2^CNT_WIDTH-1.
REQ-023 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; push into an empty FIFO SHALL not pop in the same cycle.

Reset
REQ-024 On rst=1, asynchronously: FIFO empty, din_full=0, all wen_x=0, all dout_x=0, all cnt_x=0, overflow=0.
REQ-025 Reset mid-operation SHALL discard all buffered packets; no wen_x SHALL assert in the first cycle after rst deasserts.

Structure
REQ-026 SHALL take field bit positions (DX/DY MSB/LSB) and direction ADD constants from a shared package used by all router blocks.
REQ-027 SHALL instantiate one sub-module, sync_fifo (DATA_WIDTH x FIFO_DEPTH, push/pop, full/empty), with decode, output registers and counters in the top level.

Verification
REQ-028 ADD=-1, dx=3, dy=0, full_a=0 -> dout_a dx=2, wen_a=1 at push+2, cnt_a=1.
REQ-029 dx=0, dy=-1 -> wen_c=1, dout_c lacks dx bits; dx=0, dy=0 -> wen_b=1.
REQ-030 full_a=1 with 5 pushes (depth 4) -> din_full=1 after 4, 5th dropped, overflow=1; release full_a -> 4 packets out in order on consecutive cycles.
REQ-031 Head to a blocked by full_a, second packet to b -> b not forwarded before a (in-order check).
REQ-032 rst asserted with 3 packets buffered -> all outputs 0 immediately, no wen after release.
REQ-033 CNT_WIDTH=2, 5 packets to b -> cnt_b=3 saturated.
